// File: rtl/reg_file.sv
// reg_file: 2**ADDR_WIDTH x DATA_WIDTH register file (RISC-V x0..x31 style).
// Two independent combinational read ports and one synchronous write port.
// x0 is hard-wired to zero. Reset asynchronously clears every register.
// There is no write-through bypass: a read of the address being written
// returns the old contents until the clock edge commits the write.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  // Current contents of every register, x0 included, as seen by the read ports.
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] w_regs;

  // x0 has no storage; it always reads as zero.
  assign w_regs[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_WIDTH-1:0] r_data;
      logic                  w_wr_en;

      assign w_wr_en = we && (wa == ADDR_WIDTH'(gi));

      // Register gi: cleared immediately on reset, loaded with wd when addressed.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_data <= '0;
        end else if (w_wr_en) begin
          r_data <= wd;
        end
      end

      assign w_regs[gi] = r_data;
    end
  endgenerate

  // Independent combinational read ports.
  assign rd1 = w_regs[ra1];
  assign rd2 = w_regs[ra2];

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: self-checking bench for reg_file. Directed scenarios for the
// named behaviours plus a randomized phase checked against an array model.
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [AW-1:0] ra1, ra2, wa;
  logic [DW-1:0] wd;
  logic [DW-1:0] rd1, rd2;

  reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .we(we), .ra1(ra1), .ra2(ra2),
    .wa(wa), .wd(wd), .rd1(rd1), .rd2(rd2)
  );

  always #5 clk = ~clk;

  // Reference model: plain array of register values.
  logic [DW-1:0] model [NR];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  // One write through the clock edge; inputs change away from the edge.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; wa = a; wd = d;
    @(posedge clk); #1;
    if (a != 0) model[a] = d;
    $display("write x%0d <= %h", a, d);
    we = 1'b0;
  endtask

  task automatic check_read(input string tag, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    ra1 = a1; ra2 = a2;
    #1;
    check({tag, "_rd1"}, rd1, model[a1]);
    check({tag, "_rd2"}, rd2, model[a2]);
    $display("read x%0d=%h x%0d=%h", a1, rd1, a2, rd2);
  endtask

  task automatic apply_reset();
    rst = 1'b1; #1;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic [DW-1:0] pre;
    rst = 1'b1; we = 1'b0; ra1 = '0; ra2 = '0; wa = '0; wd = '0;
    model_clear();
    #2;
    // Reset state visible before any clock edge.
    check("reset_rd1", rd1, 32'h0);
    check("reset_rd2", rd2, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; #1;

    // Basic write/read.
    do_write(5'd1, 32'd1);
    do_write(5'd2, 32'd2);
    do_write(5'd3, 32'd3);
    ra1 = 5'd2; ra2 = 5'd3; #1;
    check("basic_rd1_x2", rd1, 32'd2);
    check("basic_rd2_x3", rd2, 32'd3);
    ra2 = 5'd1; #1;
    check("basic_rd2_x1", rd2, 32'd1);

    // x0 hard-wired.
    do_write(5'd0, 32'hDEADBEEF);
    ra1 = 5'd0; ra2 = 5'd0; #1;
    check("x0_rd1", rd1, 32'h0);
    check("x0_rd2", rd2, 32'h0);

    // Write-enable gating.
    do_write(5'd5, 32'h1234_5678);
    we = 1'b0; wa = 5'd5; wd = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    ra1 = 5'd5; #1;
    check("we_gate_x5", rd1, 32'h1234_5678);

    // Same-cycle read of the write address: old value until the edge.
    @(negedge clk);
    ra1 = 5'd7; ra2 = 5'd7;
    we = 1'b1; wa = 5'd7; wd = 32'hA5A5_A5A5; #1;
    check("nobypass_rd1_old", rd1, 32'h0);
    check("nobypass_rd2_old", rd2, 32'h0);
    @(posedge clk); #1;
    we = 1'b0; model[7] = 32'hA5A5_A5A5;
    check("nobypass_rd1_new", rd1, 32'hA5A5_A5A5);
    check("nobypass_rd2_new", rd2, 32'hA5A5_A5A5);

    // Back-to-back writes to the same address: last one wins.
    do_write(5'd9, 32'h1111_1111);
    do_write(5'd9, 32'h2222_2222);
    do_write(5'd10, 32'h3333_3333);
    check_read("b2b", 5'd9, 5'd10);

    // Async reset: fill 1..31 with index, assert rst between edges.
    for (int i = 1; i < NR; i++) do_write(AW'(i), DW'(i));
    check_read("fill", 5'd17, 5'd31);
    @(negedge clk); #2;
    ra1 = 5'd17; ra2 = 5'd31;
    rst = 1'b1; #1;
    check("async_rst_rd1", rd1, 32'h0);
    check("async_rst_rd2", rd2, 32'h0);
    model_clear();
    // Writes during reset are ignored; all addresses read zero.
    we = 1'b1; wa = 5'd4; wd = 32'hCAFE_F00D;
    @(posedge clk); #1;
    we = 1'b0;
    for (int i = 0; i < NR; i++) begin
      ra1 = AW'(i); ra2 = AW'(NR - 1 - i); #1;
      check("rst_sweep_rd1", rd1, 32'h0);
      check("rst_sweep_rd2", rd2, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0; #1;
    // First edge after reset performs a normal write.
    do_write(5'd4, 32'h0BAD_F00D);
    check_read("post_rst", 5'd4, 5'd0);

    // Full sweep with ~index.
    for (int i = 1; i < NR; i++) do_write(AW'(i), ~DW'(i));
    for (int i = 0; i < NR; i++) check_read("sweep", AW'(i), AW'(NR - 1 - i));

    // Randomized phase against the model.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 49) == 0) begin
        apply_reset();
        $display("async reset applied");
      end
      we  = 1'($urandom_range(0, 1));
      wa  = AW'($urandom_range(0, NR - 1));
      wd  = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NR - 1));
      ra2 = AW'($urandom_range(0, NR - 1));
      #1;
      pre = model[ra1];
      check("rand_pre_rd1", rd1, pre);
      check("rand_pre_rd2", rd2, model[ra2]);
      @(posedge clk); #1;
      if (we && wa != 0) model[wa] = wd;
      check("rand_post_rd1", rd1, model[ra1]);
      check("rand_post_rd2", rd2, model[ra2]);
      $display("rand we=%0b wa=%0d wd=%h ra1=%0d rd1=%h ra2=%0d rd2=%h",
               we, wa, wd, ra1, rd1, ra2, rd2);
      we = 1'b0;
    end

    // Reset overriding a write on the same edge.
    @(negedge clk);
    we = 1'b1; wa = 5'd12; wd = 32'h7777_7777; rst = 1'b1;
    model_clear();
    @(posedge clk); #1;
    ra1 = 5'd12; ra2 = 5'd12; #1;
    check("rst_override_rd1", rd1, 32'h0);
    check("rst_override_rd2", rd2, 32'h0);
    we = 1'b0;
    @(negedge clk); rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
